acc_reg_bank: RTL and testbench

ACC_REG_BANK -- requirements
Module: acc_reg_bank

---
 rtl/acc_reg_bank.sv | 118 +++++++++++
 tb/tb_acc_reg_bank.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_reg_bank.sv
// Accumulator/status register bank with a shadow bank for whole-bank snapshot.
// SAVE/RESTORE copy one word per cycle; operand reads may forward the in-flight write.
module acc_reg_bank #(
  parameter int unsigned W      = 8,
  parameter int unsigned PW     = 4,
  parameter int unsigned BYPASS = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_addr,
  input  logic [W-1:0]  dat_in,
  input  logic          flag_we,
  input  logic          flag_in,
  input  logic [PW-1:0] rd_addr_a,
  input  logic [PW-1:0] rd_addr_b,
  output logic [W-1:0]  dat_a_out,
  output logic [W-1:0]  dat_b_out,
  output logic [W-1:0]  dat_acc_out,
  output logic          dat_flag_out,
  input  logic          save_req,
  input  logic          restore_req,
  output logic          busy,
  output logic          op_done,
  output logic          snap_valid
);

  localparam int unsigned   D   = 1 << PW;
  localparam logic [PW-1:0] TOP = PW'(D - 1);

  typedef enum logic [1:0] {IDLE, SAVE, RESTORE} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] idx_q, idx_d;
  logic          busy_q, busy_d;
  logic          op_done_q, op_done_d;
  logic          snap_q, snap_d;
  logic [W-1:0]  regs_q [D];
  logic [W-1:0]  regs_d [D];
  logic [W-1:0]  shd_q  [D];
  logic          last_c;
  logic          fwd_ok_c;

  assign last_c = (idx_q == TOP);

  // Next-state: host writes only in IDLE; sequences walk idx from 0 to D-1.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    op_done_d = 1'b0;
    snap_d    = snap_q;
    regs_d    = regs_q;
    case (state_q)
      IDLE: begin
        if (wr_en)   regs_d[wr_addr] = dat_in;
        if (flag_we) regs_d[TOP][0]  = flag_in;
        if (save_req) begin
          state_d = SAVE;
          idx_d   = '0;
        end else if (restore_req && snap_q) begin
          state_d = RESTORE;
          idx_d   = '0;
        end
      end
      SAVE: begin
        idx_d = PW'(idx_q + 1'b1);
        if (last_c) begin
          state_d   = IDLE;
          op_done_d = 1'b1;
          snap_d    = 1'b1;
        end
      end
      RESTORE: begin
        regs_d[idx_q] = shd_q[idx_q];
        idx_d         = PW'(idx_q + 1'b1);
        if (last_c) begin
          state_d   = IDLE;
          op_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      op_done_q <= 1'b0;
      snap_q    <= 1'b0;
      regs_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      op_done_q <= op_done_d;
      snap_q    <= snap_d;
      regs_q    <= regs_d;
    end
  end

  // Shadow bank is deliberately not reset; snap_valid qualifies its contents.
  always_ff @(posedge clk) begin
    if (state_q == SAVE) shd_q[idx_q] <= regs_q[idx_q];
  end

  assign fwd_ok_c     = (BYPASS != 0) && wr_en && !busy_q;
  assign dat_a_out    = (fwd_ok_c && (rd_addr_a == wr_addr)) ? dat_in : regs_q[rd_addr_a];
  assign dat_b_out    = (fwd_ok_c && (rd_addr_b == wr_addr)) ? dat_in : regs_q[rd_addr_b];
  assign dat_acc_out  = regs_q[0];
  assign dat_flag_out = regs_q[TOP][0];
  assign busy         = busy_q;
  assign op_done      = op_done_q;
  assign snap_valid   = snap_q;

endmodule

// File: tb/tb_acc_reg_bank.sv
// Directed bench for acc_reg_bank: a forwarding instance and a plain instance share stimulus.
module tb_acc_reg_bank;
  localparam int unsigned W  = 8;
  localparam int unsigned PW = 4;
  localparam int unsigned D  = 16;

  logic          clk = 1'b0;
  logic          reset_n, wr_en, flag_we, flag_in, save_req, restore_req;
  logic [PW-1:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [W-1:0]  dat_in;
  logic [W-1:0]  a1, b1, acc1, a0, b0, acc0;
  logic          flag1, busy1, done1, snap1, flag0, busy0, done0, snap0;
  int            checks = 0;
  int            failures = 0;
  int            cnt;

  always #5 clk = ~clk;

  acc_reg_bank #(.W(W), .PW(PW), .BYPASS(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
    .flag_we(flag_we), .flag_in(flag_in), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .dat_a_out(a1), .dat_b_out(b1), .dat_acc_out(acc1), .dat_flag_out(flag1),
    .save_req(save_req), .restore_req(restore_req), .busy(busy1), .op_done(done1),
    .snap_valid(snap1));

  acc_reg_bank #(.W(W), .PW(PW), .BYPASS(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
    .flag_we(flag_we), .flag_in(flag_in), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .dat_a_out(a0), .dat_b_out(b0), .dat_acc_out(acc0), .dat_flag_out(flag0),
    .save_req(save_req), .restore_req(restore_req), .busy(busy0), .op_done(done0),
    .snap_valid(snap0));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [PW-1:0] a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = a; dat_in = d;
    step();
    wr_en = 1'b0;
  endtask

  // Counts busy cycles of a running sequence; optional partial-restore probe at cycle 8.
  task automatic run_seq(input bit mid, output int n);
    n = 0;
    while (busy1 === 1'b1 && n < 40) begin
      step();
      wr_en = 1'b0;
      n++;
      if (mid && n == 8) begin
        checks++;
        if (a1 !== 8'h07) begin failures++; $display("FAIL mid_restore_r7 got=%h exp=07", a1); end
        checks++;
        if (b1 !== 8'hFF) begin failures++; $display("FAIL mid_restore_r8 got=%h exp=ff", b1); end
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1; wr_en = 0; flag_we = 0; flag_in = 0; save_req = 0; restore_req = 0;
    wr_addr = '0; dat_in = '0; rd_addr_a = 4'd3; rd_addr_b = 4'd15;
    #1 reset_n = 1'b0;
    #2;
    checks++;
    if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy1); end
    checks++;
    if (done1 !== 1'b0) begin failures++; $display("FAIL reset_op_done got=%b exp=0", done1); end
    checks++;
    if (snap1 !== 1'b0) begin failures++; $display("FAIL reset_snap got=%b exp=0", snap1); end
    checks++;
    if (acc1 !== 8'h00) begin failures++; $display("FAIL reset_acc got=%h exp=00", acc1); end
    checks++;
    if (a1 !== 8'h00 || b1 !== 8'h00 || flag1 !== 1'b0) begin
      failures++; $display("FAIL reset_regs got=%h/%h/%b exp=00/00/0", a1, b1, flag1);
    end
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_rw();
    wr(4'd3, 8'h5A);
    wr(4'd0, 8'h11);
    rd_addr_a = 4'd3;
    #1;
    checks++;
    if (a1 !== 8'h5A || a0 !== 8'h5A) begin failures++; $display("FAIL rw_r3 got=%h/%h exp=5a", a1, a0); end
    checks++;
    if (acc1 !== 8'h11) begin failures++; $display("FAIL rw_acc got=%h exp=11", acc1); end
    checks++;
    if (flag1 !== 1'b0) begin failures++; $display("FAIL rw_flag got=%b exp=0", flag1); end
  endtask

  task automatic test_flag();
    wr_en = 1; wr_addr = 4'd15; dat_in = 8'hF0; flag_we = 1; flag_in = 1;
    step();
    wr_en = 0; flag_we = 0; rd_addr_a = 4'd15;
    #1;
    checks++;
    if (a1 !== 8'hF1) begin failures++; $display("FAIL flag_merge got=%h exp=f1", a1); end
    checks++;
    if (flag1 !== 1'b1) begin failures++; $display("FAIL flag_out got=%b exp=1", flag1); end
    flag_we = 1; flag_in = 0;
    step();
    flag_we = 0;
    checks++;
    if (a1 !== 8'hF0 || flag1 !== 1'b0) begin
      failures++; $display("FAIL flag_only got=%h/%b exp=f0/0", a1, flag1);
    end
  endtask

  task automatic test_restore_invalid();
    restore_req = 1;
    step();
    restore_req = 0;
    checks++;
    if (busy1 !== 1'b0) begin failures++; $display("FAIL inv_restore_busy got=%b exp=0", busy1); end
    step();
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      failures++; $display("FAIL inv_restore_done got=%b/%b exp=0/0", busy1, done1);
    end
  endtask

  task automatic test_save_restore();
    for (int i = 0; i < D; i++) wr(PW'(i), W'(i));
    save_req = 1;
    step();
    save_req = 0;
    checks++;
    if (busy1 !== 1'b1) begin failures++; $display("FAIL save_start got=%b exp=1", busy1); end
    wr_en = 1; wr_addr = 4'd2; dat_in = 8'hAA;
    run_seq(1'b0, cnt);
    checks++;
    if (cnt !== 16) begin failures++; $display("FAIL save_len got=%0d exp=16", cnt); end
    checks++;
    if (done1 !== 1'b1 || snap1 !== 1'b1) begin
      failures++; $display("FAIL save_done got=%b/%b exp=1/1", done1, snap1);
    end
    step();
    checks++;
    if (done1 !== 1'b0) begin failures++; $display("FAIL save_done_pulse got=%b exp=0", done1); end
    rd_addr_a = 4'd2;
    #1;
    checks++;
    if (a1 !== 8'h02) begin failures++; $display("FAIL busy_write_drop got=%h exp=02", a1); end
    for (int i = 0; i < D; i++) wr(PW'(i), 8'hFF);
    rd_addr_a = 4'd7; rd_addr_b = 4'd8;
    #1;
    checks++;
    if (a1 !== 8'hFF) begin failures++; $display("FAIL overwrite got=%h exp=ff", a1); end
    restore_req = 1;
    step();
    restore_req = 0;
    checks++;
    if (busy1 !== 1'b1) begin failures++; $display("FAIL restore_start got=%b exp=1", busy1); end
    run_seq(1'b1, cnt);
    checks++;
    if (cnt !== 16 || done1 !== 1'b1) begin
      failures++; $display("FAIL restore_len got=%0d/%b exp=16/1", cnt, done1);
    end
    for (int i = 0; i < D; i++) begin
      rd_addr_a = PW'(i);
      step();
      checks++;
      if (a1 !== W'(i)) begin failures++; $display("FAIL restore_r%0d got=%h exp=%h", i, a1, W'(i)); end
    end
    checks++;
    if (flag1 !== 1'b1 || snap1 !== 1'b1) begin
      failures++; $display("FAIL restore_flag_snap got=%b/%b exp=1/1", flag1, snap1);
    end
  endtask

  task automatic test_back_to_back();
    wr(4'd1, 8'h77);
    save_req = 1; restore_req = 1;
    step();
    save_req = 0; restore_req = 0;
    run_seq(1'b0, cnt);
    checks++;
    if (cnt !== 16 || done1 !== 1'b1) begin
      failures++; $display("FAIL simul_len got=%0d/%b exp=16/1", cnt, done1);
    end
    save_req = 1;
    step();
    save_req = 0;
    checks++;
    if (busy1 !== 1'b1) begin failures++; $display("FAIL save_in_done got=%b exp=1", busy1); end
    run_seq(1'b0, cnt);
    checks++;
    if (cnt !== 16) begin failures++; $display("FAIL b2b_len got=%0d exp=16", cnt); end
    rd_addr_a = 4'd1;
    #1;
    checks++;
    if (a1 !== 8'h77) begin failures++; $display("FAIL simul_save_wins got=%h exp=77", a1); end
  endtask

  task automatic test_reset_mid();
    save_req = 1;
    step();
    save_req = 0;
    repeat (6) step();
    #2 reset_n = 1'b0;
    rd_addr_a = 4'd5;
    #1;
    checks++;
    if (busy1 !== 1'b0 || snap1 !== 1'b0) begin
      failures++; $display("FAIL mid_reset_state got=%b/%b exp=0/0", busy1, snap1);
    end
    checks++;
    if (acc1 !== 8'h00 || a1 !== 8'h00) begin
      failures++; $display("FAIL mid_reset_regs got=%h/%h exp=00/00", acc1, a1);
    end
    step();
    #2 reset_n = 1'b1;
    step();
    step();
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      failures++; $display("FAIL mid_reset_no_done got=%b/%b exp=0/0", busy1, done1);
    end
  endtask

  task automatic test_bypass();
    rd_addr_b = 4'd5;
    wr_en = 1; wr_addr = 4'd5; dat_in = 8'h3C;
    #1;
    checks++;
    if (b1 !== 8'h3C) begin failures++; $display("FAIL bypass_b got=%h exp=3c", b1); end
    checks++;
    if (b0 !== 8'h00) begin failures++; $display("FAIL nobypass_b got=%h exp=00", b0); end
    step();
    wr_en = 0;
    checks++;
    if (b0 !== 8'h3C) begin failures++; $display("FAIL nobypass_after got=%h exp=3c", b0); end
    rd_addr_a = 4'd0;
    wr_en = 1; wr_addr = 4'd0; dat_in = 8'h99;
    #1;
    checks++;
    if (a1 !== 8'h99 || acc1 !== 8'h00) begin
      failures++; $display("FAIL acc_not_bypassed got=%h/%h exp=99/00", a1, acc1);
    end
    step();
    wr_en = 0;
    checks++;
    if (acc1 !== 8'h99) begin failures++; $display("FAIL acc_write got=%h exp=99", acc1); end
  endtask

  initial begin
    test_reset();
    test_rw();
    test_flag();
    test_restore_invalid();
    test_save_restore();
    test_back_to_back();
    test_reset_mid();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
